// File: rtl/tile_pkg.sv
// Shared tile geometry defaults and the writer FSM state encoding,
// used by both the tile writer and the downstream tile reader.
package tile_pkg;

    localparam int TILE_W_DEF    = 24;
    localparam int TILE_H_DEF    = 24;
    localparam int PIX_BITS_DEF  = 8;
    localparam int WORD_BITS_DEF = 256;

    typedef enum logic [1:0] {
        ST_FILL      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_WAIT_BANK = 2'd2
    } wr_state_e;

endpackage

// File: rtl/tile_bank_ctrl.sv
// Ping-pong bank bookkeeping: per-bank full flags plus the write and read
// bank pointers. A release and a tile completion may land in the same cycle.
module tile_bank_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic tile_done,
    input  logic tile_release,
    output logic wr_bank,
    output logic rd_bank,
    output logic wr_full,
    output logic alt_bank_free,
    output logic tile_valid
);

    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic       release_ok;

    // A release is only honoured while the read bank actually holds a tile.
    assign release_ok = tile_release && full_q[rd_bank_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (release_ok) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        if (tile_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
    end

    // Whether the other bank will be empty next cycle, counting a release now.
    assign alt_bank_free = !full_q[~wr_bank_q] || (release_ok && (rd_bank_q != wr_bank_q));

    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;
    assign wr_full    = full_q[wr_bank_q];
    assign tile_valid = full_q[rd_bank_q];

endmodule

// File: rtl/tile_writer.sv
// Packs raster pixels into one BRAM word per tile row and writes whole tiles
// into two ping-pong banks; s_ready/s_valid is a plain valid/ready handshake.
module tile_writer
    import tile_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR   = 12'h000,
    parameter logic [11:0] BANK_STRIDE = 12'h020,
    parameter int          TILE_W      = TILE_W_DEF,
    parameter int          TILE_H      = TILE_H_DEF,
    parameter int          WORD_BITS   = WORD_BITS_DEF,
    parameter int          PIX_BITS    = PIX_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIX_BITS-1:0]  s_pixel,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 bram_we,
    output logic [11:0]          bram_addr,
    output logic [WORD_BITS-1:0] bram_wdata,
    output logic                 tile_valid,
    output logic                 tile_bank,
    input  logic                 tile_release,
    output logic [1:0]           dbg_state
);

    localparam int XW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int RW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam logic [XW-1:0] X_LAST   = XW'(TILE_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(TILE_H - 1);

    wr_state_e            state_q, state_d;
    logic [XW-1:0]        x_q, x_d;
    logic [RW-1:0]        row_q, row_d;
    logic [WORD_BITS-1:0] buf_q, buf_d;
    logic                 tile_done;
    logic                 wr_bank;
    logic                 wr_full;
    logic                 alt_bank_free;

    tile_bank_ctrl u_bank_ctrl (
        .clk           (clk),
        .rst           (rst),
        .tile_done     (tile_done),
        .tile_release  (tile_release),
        .wr_bank       (wr_bank),
        .rd_bank       (tile_bank),
        .wr_full       (wr_full),
        .alt_bank_free (alt_bank_free),
        .tile_valid    (tile_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            x_q     <= '0;
            row_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            row_q   <= row_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        row_d      = row_q;
        buf_d      = buf_q;
        tile_done  = 1'b0;
        s_ready    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = BASE_ADDR + (wr_bank ? BANK_STRIDE : 12'h000) + 12'(row_q);
        bram_wdata = buf_q;
        case (state_q)
            ST_FILL: begin
                s_ready = !rst && !wr_full;
                if (s_valid && s_ready) begin
                    // Bits above the last pixel lane are never written, so stay zero.
                    for (int i = 0; i < TILE_W; i++) begin
                        if (x_q == XW'(i)) begin
                            buf_d[i*PIX_BITS +: PIX_BITS] = s_pixel;
                        end
                    end
                    if (x_q == X_LAST) begin
                        x_d     = '0;
                        state_d = ST_WRITE;
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            ST_WRITE: begin
                bram_we = 1'b1;
                if (row_q == ROW_LAST) begin
                    tile_done = 1'b1;
                    row_d     = '0;
                    state_d   = alt_bank_free ? ST_FILL : ST_WAIT_BANK;
                end else begin
                    row_d   = row_q + RW'(1);
                    state_d = ST_FILL;
                end
            end
            ST_WAIT_BANK: begin
                if (!wr_full) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_tile_writer.sv
// Directed bench for tile_writer: a reset/handshake vector table, then
// hand-written tile sequences checked against a write scoreboard.
module tb_tile_writer;
    import tile_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   s_pixel;
    logic         s_valid;
    logic         s_ready;
    logic         bram_we;
    logic [11:0]  bram_addr;
    logic [255:0] bram_wdata;
    logic         tile_valid;
    logic         tile_bank;
    logic         tile_release;
    logic [1:0]   dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [267:0] exp_q[$];
    logic [255:0] row0_data;
    logic         row0_seen = 1'b0;

    typedef struct {
        logic rst;
        logic s_valid;
        logic rel;
        logic exp_ready;
        logic exp_tv;
        logic exp_tb;
        logic exp_we;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    tile_writer dut (
        .clk          (clk),
        .rst          (rst),
        .s_pixel      (s_pixel),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_wdata   (bram_wdata),
        .tile_valid   (tile_valid),
        .tile_bank    (tile_bank),
        .tile_release (tile_release),
        .dbg_state    (dbg_state)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every BRAM write must match the head of the expected queue.
    always @(negedge clk) begin
        logic [267:0] w;
        if (bram_we !== 1'b0) begin
            check("ready_during_write", {255'b0, s_ready}, 256'b0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr %0h, expected no write", bram_addr);
            end else begin
                w = exp_q.pop_front();
                check("write_addr", {244'b0, bram_addr}, {244'b0, w[267:256]});
                check("write_data", bram_wdata, w[255:0]);
                if (bram_addr == 12'h000 && !row0_seen) begin
                    row0_data = bram_wdata;
                    row0_seen = 1'b1;
                end
            end
        end
    end

    function automatic logic [7:0] pix(input int seed, input int r, input int x);
        return 8'(seed + r * 24 + x);
    endfunction

    // Called at #1 after a rising edge; returns #1 after the accepting edge.
    task automatic push_pixel(input logic [7:0] p, input bit gaps);
        int  budget;
        logic acc;
        s_valid = 1'b0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_pixel = p;
        budget  = 0;
        forever begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc === 1'b1) break;
            budget++;
            if (budget > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: pixel %0h not accepted in 200 cycles", p);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic send_row(input int seed, input int r, input bit bank, input bit gaps,
                            input bit expect_wr, input int n_pix);
        logic [255:0] w;
        logic [11:0]  a;
        if (expect_wr) begin
            w = '0;
            for (int x = 0; x < 24; x++) w[x*8 +: 8] = pix(seed, r, x);
            a = (bank ? 12'h020 : 12'h000) + 12'(r);
            exp_q.push_back({a, w});
        end
        for (int x = 0; x < n_pix; x++) push_pixel(pix(seed, r, x), gaps);
    endtask

    // Streams a whole tile; returns while the last-row WRITE cycle is current.
    task automatic send_tile(input int seed, input bit bank, input bit gaps);
        for (int r = 0; r < 23; r++) send_row(seed, r, bank, gaps, 1'b1, 24);
        send_row(seed, 23, bank, gaps, 1'b1, 23);
        push_pixel(pix(seed, 23, 23), gaps);
    endtask

    task automatic pulse_release();
        tile_release = 1'b1;
        @(posedge clk);
        #1;
        tile_release = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        s_valid      = 1'b0;
        s_pixel      = 8'h00;
        tile_release = 1'b0;

        //            rst   val   rel   rdy   tv    tb    we
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            rst          = vecs[i].rst;
            s_valid      = vecs[i].s_valid;
            s_pixel      = 8'(i);
            tile_release = vecs[i].rel;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {252'b0, s_ready, tile_valid, tile_bank, bram_we},
                  {252'b0, vecs[i].exp_ready, vecs[i].exp_tv, vecs[i].exp_tb, vecs[i].exp_we});
            @(posedge clk);
            #1;
        end
        s_valid      = 1'b0;
        tile_release = 1'b0;

        // Clean reset, then an ignored release on an empty pair of banks.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pulse_release();
        @(negedge clk);
        check("idle_rel_tv", {255'b0, tile_valid}, 256'd0);
        check("idle_rel_tb", {255'b0, tile_bank}, 256'd0);
        check("idle_rel_ready", {255'b0, s_ready}, 256'd1);
        @(posedge clk);
        #1;

        // Tile A, gap-free, bank 0.
        send_tile(0, 1'b0, 1'b0);
        @(negedge clk);
        check("a_last_write_tv", {255'b0, tile_valid}, 256'd0);
        @(posedge clk);
        @(negedge clk);
        check("a_tv", {255'b0, tile_valid}, 256'd1);
        check("a_tb", {255'b0, tile_bank}, 256'd0);
        check("a_ready", {255'b0, s_ready}, 256'd1);
        check("a_state", {254'b0, dbg_state}, {254'b0, ST_FILL});
        check("a_queue", 256'(exp_q.size()), 256'd0);
        check("a_row0_seen", {255'b0, row0_seen}, 256'd1);
        check("a_row0_byte23", {248'b0, row0_data[191:184]}, {248'b0, 8'h17});
        check("a_row0_upper", {192'b0, row0_data[255:192]}, 256'd0);
        @(posedge clk);
        #1;

        // Tile B into bank 1 with random gaps, same pixels as tile A, no release.
        send_tile(0, 1'b1, 1'b1);
        @(negedge clk);
        check("b_write_tb", {255'b0, tile_bank}, 256'd0);
        @(posedge clk);
        @(negedge clk);
        check("b_state_wait", {254'b0, dbg_state}, {254'b0, ST_WAIT_BANK});
        check("b_ready_wait", {255'b0, s_ready}, 256'd0);
        check("b_tv", {255'b0, tile_valid}, 256'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_pixel = 8'hEE;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("b_ready_stalled", {255'b0, s_ready}, 256'd0);
        check("b_queue", 256'(exp_q.size()), 256'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        pulse_release();
        @(negedge clk);
        check("rel_tb", {255'b0, tile_bank}, 256'd1);
        check("rel_tv", {255'b0, tile_valid}, 256'd1);
        @(negedge clk);
        check("rel_ready", {255'b0, s_ready}, 256'd1);
        check("rel_state", {254'b0, dbg_state}, {254'b0, ST_FILL});
        @(posedge clk);
        #1;

        // Free bank 1 too, so the pair is empty again.
        pulse_release();
        @(negedge clk);
        check("rel2_tv", {255'b0, tile_valid}, 256'd0);
        check("rel2_tb", {255'b0, tile_bank}, 256'd0);
        @(posedge clk);
        #1;

        // Tile C into bank 0.
        send_tile(8'h55, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("c_tv", {255'b0, tile_valid}, 256'd1);
        check("c_tb", {255'b0, tile_bank}, 256'd0);
        @(posedge clk);
        #1;

        // Tile D into bank 1, releasing bank 0 during its last-row WRITE.
        send_tile(8'h9A, 1'b1, 1'b1);
        pulse_release();
        @(negedge clk);
        check("d_tv", {255'b0, tile_valid}, 256'd1);
        check("d_tb", {255'b0, tile_bank}, 256'd1);
        check("d_state", {254'b0, dbg_state}, {254'b0, ST_FILL});
        check("d_ready", {255'b0, s_ready}, 256'd1);
        check("d_queue", 256'(exp_q.size()), 256'd0);
        @(posedge clk);
        #1;

        // Partial tile E, reset after 10 pixels of row 5.
        for (int r = 0; r < 5; r++) send_row(8'h21, r, 1'b0, 1'b0, 1'b1, 24);
        send_row(8'h21, 5, 1'b0, 1'b0, 1'b0, 10);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", {255'b0, s_ready}, 256'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {255'b0, s_ready}, 256'd1);
        check("post_rst_tv", {255'b0, tile_valid}, 256'd0);
        check("post_rst_tb", {255'b0, tile_bank}, 256'd0);
        repeat (4) @(posedge clk);
        #1;
        send_row(8'h33, 0, 1'b0, 1'b0, 1'b1, 24);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("final_queue", 256'(exp_q.size()), 256'd0);
        check("final_tv", {255'b0, tile_valid}, 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tile_writer.md
TILE_WRITER -- requirements
Module: tile_writer

Interface
REQ-001 Parameter BASE_ADDR, default 12'h000: BRAM word address of bank 0, row 0.
REQ-002 Parameter BANK_STRIDE, default 12'h020: address offset between bank 0 and bank 1.
REQ-003 Parameter TILE_W, default 24: pixels per tile row.
REQ-004 Parameter TILE_H, default 24: rows per tile.
REQ-005 Parameter WORD_BITS, default 256: BRAM word width.
REQ-006 Parameter PIX_BITS, default 8: bits per pixel.
REQ-007 clk  input  1: single clock; all logic on its rising edge.
REQ-008 rst  input  1: reset, synchronous, active-high.
REQ-009 s_pixel  input  PIX_BITS: incoming raster-order pixel.
REQ-010 s_valid  input  1: s_pixel valid.
REQ-011 s_ready  output  1: writer accepts the pixel this cycle.
REQ-012 bram_we  output  1: BRAM write enable, one-cycle pulse per row.
REQ-013 bram_addr  output  12: BRAM write word address.
REQ-014 bram_wdata  output  WORD_BITS: packed row word.
REQ-015 tile_valid  output  1: at least one bank holds a complete tile.
REQ-016 tile_bank  output  1: bank the downstream tile reader must read (oldest full bank).
REQ-017 tile_release  input  1: one-cycle pulse; consumer has finished reading tile_bank.

Function
REQ-018 Accept a pixel only on a cycle where s_valid and s_ready are both 1.
REQ-019 s_ready SHALL be 1 only in state FILL while the current write bank is empty.
REQ-020 Write pixel with column index x (0..TILE_W-1) into row-buffer bits [x*PIX_BITS +: PIX_BITS]; bits at and above TILE_W*PIX_BITS SHALL be zero in every write.
REQ-021 FSM states: FILL, WRITE, WAIT_BANK.
REQ-022 FILL -> WRITE on acceptance of the pixel at x==TILE_W-1; x wraps to 0.
REQ-023 In WRITE, drive bram_we=1 for exactly one cycle, with bram_addr = BASE_ADDR + wr_bank*BANK_STRIDE + row and bram_wdata = the row buffer; s_ready=0.
REQ-024 After WRITE with row<TILE_H-1: row increments and the FSM returns to FILL.
REQ-025 After WRITE with row==TILE_H-1: set full[wr_bank], toggle wr_bank, set row to 0; go to FILL if the new wr_bank is empty, else to WAIT_BANK.
REQ-026 WAIT_BANK -> FILL on the first cycle in which full[wr_bank] is 0.
REQ-027 tile_valid = full[rd_bank]; tile_bank = rd_bank; tile_valid rises the cycle after the last-row WRITE cycle.
REQ-028 tile_release with tile_valid=1 clears full[rd_bank] and toggles rd_bank; tile_release with tile_valid=0 SHALL be ignored.
REQ-029 Release and a tile completion in the same cycle on different banks SHALL both take effect.
REQ-030 Both banks full: s_ready=0 and no BRAM writes occur until a release.
REQ-031 Address arithmetic is 12-bit and wraps modulo 4096 without error flagging.
REQ-032 bram_we=0 in every state other than WRITE; bram_addr and bram_wdata are don't-care when bram_we=0.

Reset
REQ-033 rst=1 at a rising edge SHALL force FILL, x=0, row=0, wr_bank=0, rd_bank=0, full={0,0}, row buffer=0.
REQ-034 Outputs during and after a reset cycle: s_ready=0 while rst=1, bram_we=0, tile_valid=0, tile_bank=0; s_ready=1 on the first cycle with rst=0.
REQ-035 Reset mid-row or mid-tile SHALL discard partial data; no BRAM write SHALL be issued for it.

Structure
REQ-036 Package tile_pkg SHALL hold the FSM state enum and the shared TILE_W/TILE_H/PIX_BITS/WORD_BITS defaults used by tile_writer and the tile reader.
REQ-037 Bank full flags and the rd_bank/wr_bank pointers SHALL live in one sub-module, tile_bank_ctrl; packing and the FSM SHALL live in tile_writer.

Verification
REQ-038 Stream 576 pixels, value = (row*24+x)&8'hFF, s_valid held at 1 -> 24 writes to addresses 0x000..0x017; word 0 byte 23 = 8'h17 and bits [255:192]=0; tile_valid=1, tile_bank=0.
REQ-039 Continue streaming 576 more pixels without a release -> writes to 0x020..0x037, then s_ready=0 (WAIT_BANK); release -> tile_bank=1, s_ready=1 the cycle after.
REQ-040 Random s_valid gaps at 50% -> write data is identical to the gap-free run; no write cycle occurs with s_ready=1.
REQ-041 Pulse tile_release with tile_valid=0 -> no state change; later tile completion still reports tile_bank=0.
REQ-042 Assert rst after 10 pixels of row 5 -> no write follows; the next 24 pixels write to address 0x000.
REQ-043 Align a release of bank 0 with the last-row WRITE of bank 1 -> full={0,1} and tile_bank=1 the next cycle; the FSM returns to FILL.
